// File: rtl/signed_operand_mux_rr.sv
// Round-robin NUM_CH-channel operand selector with a one-deep registered (WIDTH+1)-bit output.
// Define SIGN_EXT_EN for per-channel sign extension; without it the MSB is always zero.
module signed_operand_mux_rr #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_CH*WIDTH-1:0] In_Data,
  input  logic [NUM_CH-1:0]       In_Signed,
  input  logic [NUM_CH-1:0]       In_Valid,
  output logic [NUM_CH-1:0]       In_Ready,
  output logic [WIDTH:0]          Out_Data,
  output logic [CH_W-1:0]         Out_Ch,
  output logic                    Out_Valid,
  input  logic                    Out_Ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant;
  logic            any_valid;
  logic            load;
  logic            ext;

  logic [WIDTH-1:0] operand [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign operand[i] = In_Data[i*WIDTH +: WIDTH];
  end

  // Search starts at rr_ptr and wraps; the first requester found wins.
  always_comb begin
    int              pos;
    logic [CH_W-1:0] idx;
    logic            found;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      idx = CH_W'(pos);
      if (!found && In_Valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign any_valid = |In_Valid;

  // Reset gates load so no source sees a handshake while the stage is held in reset.
  assign load = Reset & any_valid & ((state == EMPTY) | Out_Ready);

  always_comb begin
    In_Ready = '0;
    if (load) In_Ready[grant] = 1'b1;
  end

`ifdef SIGN_EXT_EN
  assign ext = In_Signed[grant] & operand[grant][WIDTH-1];
`else
  logic signed_unused;
  assign signed_unused = ^In_Signed;
  assign ext           = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL:  if (!load && Out_Ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // The held operand is discarded on reset; sources re-offer it afterwards.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Out_Data <= '0;
      Out_Ch   <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      Out_Data <= {ext, operand[grant]};
      Out_Ch   <= grant;
      rr_ptr   <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    end
  end

  assign Out_Valid = (state == FULL);

endmodule

// File: tb/tb_signed_operand_mux_rr.sv
// Directed bench for signed_operand_mux_rr: behavioural round-robin model feeding a scoreboard
// that is checked when the output stage is consumed, plus explicit checks of named scenarios.
module tb_signed_operand_mux_rr;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

`ifdef SIGN_EXT_EN
  localparam logic [WIDTH:0] EXP_9C = 9'h19C;
`else
  localparam logic [WIDTH:0] EXP_9C = 9'h09C;
`endif

  logic                    Clk;
  logic                    Reset;
  logic [NUM_CH*WIDTH-1:0] In_Data;
  logic [NUM_CH-1:0]       In_Signed;
  logic [NUM_CH-1:0]       In_Valid;
  logic [NUM_CH-1:0]       In_Ready;
  logic [WIDTH:0]          Out_Data;
  logic [CH_W-1:0]         Out_Ch;
  logic                    Out_Valid;
  logic                    Out_Ready;

  signed_operand_mux_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_Data   (In_Data),
    .In_Signed (In_Signed),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out_Data  (Out_Data),
    .Out_Ch    (Out_Ch),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [WIDTH:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_full;
  int   m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ext_of(input int ch);
    logic [WIDTH-1:0] d;
    d = In_Data[ch*WIDTH +: WIDTH];
`ifdef SIGN_EXT_EN
    return {In_Signed[ch] & d[WIDTH-1], d};
`else
    return {1'b0, d};
`endif
  endfunction

  // One clock cycle: drive, check handshake against the model, update scoreboard, clock.
  task automatic cycle(input logic [NUM_CH-1:0] valid, input logic ready);
    int   g;
    int   c;
    logic load;
    exp_t e;
    In_Valid  = valid;
    Out_Ready = ready;
    #1;
    g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (m_ptr + k) % NUM_CH;
      if (g < 0 && valid[c]) g = c;
    end
    load = (g >= 0) && (!m_full || ready);
    check("out_valid", {31'd0, Out_Valid}, {31'd0, m_full});
    check("in_ready", {28'd0, In_Ready}, load ? (32'd1 << g) : 32'd0);
    if (m_full && ready && sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_out_data", {23'd0, Out_Data}, {23'd0, e.data});
      check("sb_out_ch", {30'd0, Out_Ch}, {30'd0, e.ch});
    end
    if (load) begin
      e.ch   = g[CH_W-1:0];
      e.data = ext_of(g);
      sb.push_back(e);
      m_ptr = (g + 1) % NUM_CH;
    end
    m_full = load ? 1'b1 : (ready ? 1'b0 : m_full);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset     = 1'b0;
    In_Valid  = '1;
    Out_Ready = 1'b1;
    In_Data   = '0;
    In_Signed = '0;
    m_full    = 1'b0;
    m_ptr     = 0;

    // Reset held with every channel requesting
    #1;
    check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    check("rst_out_data", {23'd0, Out_Data}, 32'd0);
    check("rst_out_ch", {30'd0, Out_Ch}, 32'd0);
    check("rst_in_ready", {28'd0, In_Ready}, 32'd0);
    @(posedge Clk);
    #1;
    check("rst_edge_out_valid", {31'd0, Out_Valid}, 32'd0);
    check("rst_edge_in_ready", {28'd0, In_Ready}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // Full round-robin rotation, first grant is ch0
    In_Data   = {8'hF4, 8'h33, 8'h22, 8'h11};
    In_Signed = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1);
      check("rr_out_ch", {30'd0, Out_Ch}, i % NUM_CH);
    end
    cycle(4'b0000, 1'b1);

    // Negative signed operand on ch2
    In_Data[2*WIDTH +: WIDTH] = 8'h9C;
    In_Signed = 4'b0100;
    cycle(4'b0100, 1'b1);
    check("ext_9c", {23'd0, Out_Data}, {23'd0, EXP_9C});
    check("ext_9c_ch", {30'd0, Out_Ch}, 32'd2);
    cycle(4'b0000, 1'b1);

    // Positive signed operand on ch1
    In_Data[1*WIDTH +: WIDTH] = 8'h7F;
    In_Signed = 4'b0010;
    cycle(4'b0010, 1'b1);
    check("ext_7f", {23'd0, Out_Data}, 32'h07F);
    cycle(4'b0000, 1'b1);

    // Backpressure hold, then pop and push in one cycle
    In_Data[0*WIDTH +: WIDTH] = 8'h55;
    In_Data[3*WIDTH +: WIDTH] = 8'hA0;
    In_Signed = 4'b0000;
    cycle(4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1001, 1'b0);
      check("hold_out_data", {23'd0, Out_Data}, 32'h055);
      check("hold_out_ch", {30'd0, Out_Ch}, 32'd0);
      check("hold_in_ready", {28'd0, In_Ready}, 32'd0);
    end
    cycle(4'b1000, 1'b1);
    check("pp_out_valid", {31'd0, Out_Valid}, 32'd1);
    check("pp_out_ch", {30'd0, Out_Ch}, 32'd3);
    check("pp_out_data", {23'd0, Out_Data}, 32'h0A0);

    // Asynchronous reset while FULL, then pointer restarts at ch0
    In_Valid  = 4'b1001;
    Out_Ready = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check("async_out_valid", {31'd0, Out_Valid}, 32'd0);
    check("async_in_ready", {28'd0, In_Ready}, 32'd0);
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    @(negedge Clk);
    Reset = 1'b1;
    cycle(4'b1001, 1'b1);
    check("post_rst_out_ch", {30'd0, Out_Ch}, 32'd0);
    check("post_rst_out_data", {23'd0, Out_Data}, 32'h055);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
